// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, FSM state type and parameter helpers for lfsr_encrypter
//
// Contents:
//   TAP_PATTERNS   six maximal-length 6-bit feedback tap masks
//   PREAMBLE_BYTE  byte written ahead of the plaintext
//   PT_BASE/CT_BASE plaintext / ciphertext base addresses
//   MSG_LEN        bytes written per run
//   state_t        controller states
//   tap_lookup/seed_fix/pre_len_clamp  normalise the raw go-time inputs
package lfsr_pkg;

    localparam int         NUM_TAPS                   = 6;
    localparam logic [5:0] TAP_PATTERNS [NUM_TAPS]    = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    localparam logic [7:0] PREAMBLE_BYTE              = 8'h5F;
    localparam logic [7:0] PT_BASE                    = 8'd0;
    localparam logic [7:0] CT_BASE                    = 8'd64;
    localparam int         MSG_LEN                    = 64;
    localparam logic [3:0] PRE_LEN_MIN                = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Selectors 6 and 7 have no pattern of their own and fall back to pattern 0.
    function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
        logic [5:0] pat;
        case (sel)
            3'd1:    pat = TAP_PATTERNS[1];
            3'd2:    pat = TAP_PATTERNS[2];
            3'd3:    pat = TAP_PATTERNS[3];
            3'd4:    pat = TAP_PATTERNS[4];
            3'd5:    pat = TAP_PATTERNS[5];
            default: pat = TAP_PATTERNS[0];
        endcase
        return pat;
    endfunction

    // An all-zero LFSR never leaves zero, so a zero seed is bumped to 1.
    function automatic logic [5:0] seed_fix(input logic [5:0] s);
        return (s == 6'd0) ? 6'd1 : s;
    endfunction

    function automatic logic [3:0] pre_len_clamp(input logic [3:0] p);
        return (p < PRE_LEN_MIN) ? PRE_LEN_MIN : p;
    endfunction

endpackage

// File: rtl/lfsr6b.sv
// rtl/lfsr6b.sv - 6-bit Fibonacci LFSR with parallel load
//
// Ports:
//   clk    rising-edge clock
//   en     1: shift left, feedback = XOR of (state AND taps) into bit 0
//          0: load start
//   init   asynchronous active-low clear of the register
//   taps   feedback tap mask
//   start  value loaded while en is low
//   state  current register contents
module lfsr6b (
    input  logic       clk,
    input  logic       en,
    input  logic       init,
    input  logic [5:0] taps,
    input  logic [5:0] start,
    output logic [5:0] state
);

    logic [5:0] r_state;
    logic       w_feedback;

    assign w_feedback = ^(r_state & taps);

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_state <= '0;
        end else if (en) begin
            r_state <= {r_state[4:0], w_feedback};
        end else begin
            r_state <= start;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_encrypter.sv
// rtl/lfsr_encrypter.sv - XORs a preamble plus plaintext with a 6-bit LFSR stream into memory
//
// Ports:
//   clk        rising-edge clock
//   init_n     asynchronous active-low reset
//   go         start request, honoured only in IDLE or DONE
//   tap_sel    LFSR tap pattern selector (6,7 -> pattern 0)
//   seed       LFSR start value (0 -> 1)
//   pre_len    preamble length in bytes (clamped to >= 7)
//   mem_raddr  plaintext read address
//   mem_rdata  plaintext byte, combinational read of mem_raddr
//   mem_wr_en  ciphertext write strobe, high every RUN cycle
//   mem_waddr  ciphertext write address (64 + k)
//   mem_wdata  ciphertext byte
//   done       high while in DONE
module lfsr_encrypter
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       init_n,
    input  logic       go,
    input  logic [2:0] tap_sel,
    input  logic [5:0] seed,
    input  logic [3:0] pre_len,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       done
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_start;
    logic [5:0] r_k;
    logic [5:0] r_taps;
    logic [5:0] r_seed;
    logic [3:0] r_pre_len;
    logic [5:0] w_lfsr;
    logic       w_in_run;
    logic       w_preamble;
    logic [5:0] w_pt_idx;
    logic [7:0] w_plain;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (go) begin
                    w_start      = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD:    w_state_next = RUN;
            RUN:     if (r_k == 6'(MSG_LEN - 1)) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Parameters are normalised once at go so the datapath never sees the
    // illegal tap selectors, the lockup seed or a short preamble.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_taps    <= '0;
            r_seed    <= '0;
            r_pre_len <= '0;
            r_k       <= '0;
        end else begin
            if (w_start) begin
                r_taps    <= tap_lookup(tap_sel);
                r_seed    <= seed_fix(seed);
                r_pre_len <= pre_len_clamp(pre_len);
            end
            if (r_state == LOAD) begin
                r_k <= '0;
            end else if (w_in_run) begin
                r_k <= r_k + 6'd1;
            end
        end
    end

    // Outside RUN the LFSR keeps reloading the latched seed, so the LOAD
    // cycle leaves L_0 in place for the first RUN cycle.
    lfsr6b u_lfsr (
        .clk   (clk),
        .en    (w_in_run),
        .init  (init_n),
        .taps  (r_taps),
        .start (r_seed),
        .state (w_lfsr)
    );

    assign w_in_run   = (r_state == RUN);
    assign w_preamble = (r_k < {2'b00, r_pre_len});
    assign w_pt_idx   = r_k - {2'b00, r_pre_len};
    assign w_plain    = w_preamble ? PREAMBLE_BYTE : mem_rdata;

    assign mem_wr_en = w_in_run;
    assign mem_waddr = w_in_run ? (CT_BASE + {2'b00, r_k}) : 8'h00;
    assign mem_raddr = (w_in_run && !w_preamble) ? (PT_BASE + {2'b00, w_pt_idx}) : 8'h00;
    assign mem_wdata = w_in_run ? (w_plain ^ {2'b00, w_lfsr}) : 8'h00;
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_lfsr_encrypter.sv
// tb/tb_lfsr_encrypter.sv - scoreboard bench for lfsr_encrypter
module tb_lfsr_encrypter;

    logic       clk;
    logic       init_n;
    logic       go;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [3:0] pre_len;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       done;

    logic [7:0] pt_mem [0:63];
    logic [7:0] ct_mem [0:255];
    logic [7:0] saved  [0:63];
    logic [7:0] golden [0:3] = '{8'h5E, 8'h5C, 8'h58, 8'h50};
    logic       clr_ct;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         chk_raddr;
        logic [7:0] raddr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_item;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    lfsr_encrypter dut (
        .clk       (clk),
        .init_n    (init_n),
        .go        (go),
        .tap_sel   (tap_sel),
        .seed      (seed),
        .pre_len   (pre_len),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = (mem_raddr < 8'd64) ? pt_mem[mem_raddr[5:0]] : 8'h00;

    always @(posedge clk) begin
        if (clr_ct) begin
            for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        end else if (mem_wr_en) begin
            ct_mem[mem_waddr] = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the documented rules.
    function automatic int ref_taps(input int t);
        case (t)
            1:       return 'h2D;
            2:       return 'h30;
            3:       return 'h33;
            4:       return 'h36;
            5:       return 'h39;
            default: return 'h21;
        endcase
    endfunction

    function automatic int eff_seed(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int eff_pre(input int p);
        return (p < 7) ? 7 : p;
    endfunction

    function automatic int ref_next(input int l, input int tp);
        return ((l * 2) % 64) + ($countones(l & tp) % 2);
    endfunction

    function automatic int ref_lfsr(input int t, input int s, input int n);
        int l = eff_seed(s);
        for (int i = 0; i < n; i++) l = ref_next(l, ref_taps(t));
        return l;
    endfunction

    function automatic int ref_plain(input int k, input int pl);
        if (k < pl) return 'h5F;
        return int'(pt_mem[k - pl]);
    endfunction

    task automatic push_expected(input int t, input int s, input int p);
        int   pl = eff_pre(p);
        int   tp = ref_taps(t);
        int   l  = eff_seed(s);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.addr      = 8'(64 + k);
            e.data      = 8'(ref_plain(k, pl) ^ l);
            e.chk_raddr = (k >= pl);
            e.raddr     = 8'(k - pl);
            exp_q.push_back(e);
            l = ref_next(l, tp);
        end
    endtask

    always @(negedge clk) begin
        if (init_n) begin
            if (mem_wr_en) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected write: addr 0x%0h data 0x%0h with empty scoreboard", mem_waddr, mem_wdata);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("waddr", 32'(mem_waddr), 32'(mon_item.addr));
                    check($sformatf("wdata@%0h", mon_item.addr), 32'(mem_wdata), 32'(mon_item.data));
                    if (mon_item.chk_raddr) check("raddr", 32'(mem_raddr), 32'(mon_item.raddr));
                end
            end else begin
                check("idle outputs zero", {8'h00, mem_waddr, mem_raddr, mem_wdata}, 32'h0);
            end
        end
    end

    task automatic clear_ct();
        @(negedge clk);
        clr_ct = 1'b1;
        @(negedge clk);
        clr_ct = 1'b0;
    endtask

    task automatic run_msg(input int t, input int s, input int p, input int go_at);
        int c;
        int first_wr;
        int done_c;
        int w0;
        clear_ct();
        push_expected(t, s, p);
        w0      = n_writes;
        tap_sel = 3'(t);
        seed    = 6'(s);
        pre_len = 4'(p);
        go      = 1'b1;
        @(negedge clk);
        go      = 1'b0;
        c       = 1;
        tap_sel = 3'($urandom);
        seed    = 6'($urandom);
        pre_len = 4'($urandom);
        check("load cycle done", 32'(done), 32'd0);
        check("load cycle wr_en", 32'(mem_wr_en), 32'd0);
        first_wr = 0;
        done_c   = 0;
        while (done_c == 0 && c < 200) begin
            go = (go_at != 0 && c == go_at);
            @(negedge clk);
            c++;
            if (mem_wr_en && first_wr == 0) first_wr = c;
            if (done) done_c = c;
        end
        go = 1'b0;
        check("first write cycle", 32'(first_wr), 32'd2);
        check("done cycle", 32'(done_c), 32'd66);
        check("write count", 32'(n_writes - w0), 32'd64);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("done held", 32'(done), 32'd1);
    endtask

    task automatic decrypt_check(input int t, input int s, input int p);
        int l   = eff_seed(s);
        int pl  = eff_pre(p);
        int bad = 0;
        for (int k = 0; k < 64; k++) begin
            if ((int'(ct_mem[64 + k]) ^ l) != ref_plain(k, pl)) bad++;
            l = ref_next(l, ref_taps(t));
        end
        check($sformatf("decrypt tap%0d bad bytes", t), 32'(bad), 32'd0);
    endtask

    task automatic compare_saved(input string name);
        int bad = 0;
        for (int k = 0; k < 64; k++) if (ct_mem[64 + k] !== saved[k]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic reset_mid_run();
        int c = 0;
        clear_ct();
        push_expected(2, 'h15, 9);
        tap_sel = 3'd2;
        seed    = 6'h15;
        pre_len = 4'd9;
        go      = 1'b1;
        @(negedge clk);
        go = 1'b0;
        while (!(mem_wr_en && mem_waddr == 8'd84) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("reached k=20", 32'(mem_waddr), 32'd84);
        #2 init_n = 1'b0;
        #1;
        check("async reset wr_en", 32'(mem_wr_en), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        check("async reset waddr", 32'(mem_waddr), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle after reset done", 32'(done), 32'd0);
        check("idle after reset wr_en", 32'(mem_wr_en), 32'd0);
    endtask

    initial begin
        int t;
        int s;
        int p;
        init_n  = 1'b0;
        go      = 1'b0;
        tap_sel = '0;
        seed    = '0;
        pre_len = '0;
        clr_ct  = 1'b0;
        for (int a = 0; a < 64; a++) pt_mem[a] = 8'($urandom);
        pt_mem[0] = 8'h41;

        repeat (3) @(negedge clk);
        check("reset done", 32'(done), 32'd0);
        check("reset wr_en", 32'(mem_wr_en), 32'd0);
        check("reset waddr", 32'(mem_waddr), 32'd0);
        check("reset raddr", 32'(mem_raddr), 32'd0);
        check("reset wdata", 32'(mem_wdata), 32'd0);
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle without go", 32'(done), 32'd0);

        run_msg(0, 'h01, 7, 0);
        for (int k = 0; k < 4; k++) check($sformatf("golden byte %0d", k), 32'(ct_mem[64 + k]), 32'(golden[k]));
        for (int k = 0; k < 64; k++) saved[k] = ct_mem[64 + k];
        run_msg(7, 'h00, 7, 0);
        compare_saved("tap7 seed0 equals tap0 seed1");
        run_msg(0, 'h01, 3, 0);
        compare_saved("pre_len3 equals pre_len7");

        run_msg(0, 'h2A, 10, 0);
        for (int k = 0; k < 10; k++)
            check($sformatf("preamble byte %0d", k), 32'(ct_mem[64 + k]), 32'('h5F ^ ref_lfsr(0, 'h2A, k)));
        check("first plaintext byte", 32'(ct_mem[74]), 32'('h41 ^ ref_lfsr(0, 'h2A, 10)));

        run_msg(3, 'h2B, 12, 30);
        run_msg(5, 'h11, 8, 0);

        reset_mid_run();
        run_msg(4, 'h33, 11, 0);

        for (int tt = 0; tt < 6; tt++) begin
            for (int a = 0; a < 64; a++) pt_mem[a] = 8'($urandom);
            s = int'($urandom_range(1, 63));
            p = int'($urandom_range(7, 15));
            run_msg(tt, s, p, 0);
            decrypt_check(tt, s, p);
        end

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 64; a++) pt_mem[a] = 8'($urandom);
            t = int'($urandom_range(0, 7));
            s = int'($urandom_range(0, 63));
            p = int'($urandom_range(0, 15));
            run_msg(t, s, p, int'($urandom_range(0, 60)));
            decrypt_check(t, s, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_encrypter.md
LFSR_ENCRYPTER -- requirements
Module: lfsr_encrypter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port init_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port go, input, 1 bit: start request; sampled only in IDLE or DONE.
REQ-004 SHALL have port tap_sel, input, 3 bits: index into the 6 maximal-length tap patterns 0x21, 0x2D, 0x30, 0x33, 0x36, 0x39.
REQ-005 SHALL have port seed, input, 6 bits: LFSR starting state.
REQ-006 SHALL have port pre_len, input, 4 bits: number of 0x5F preamble bytes.
REQ-007 SHALL have port mem_raddr, output, 8 bits: plaintext read address.
REQ-008 SHALL have port mem_rdata, input, 8 bits: plaintext byte; combinational (same-cycle) read of mem_raddr.
REQ-009 SHALL have port mem_wr_en, output, 1 bit: write strobe.
REQ-010 SHALL have port mem_waddr, output, 8 bits: ciphertext write address.
REQ-011 SHALL have port mem_wdata, output, 8 bits: ciphertext byte.
REQ-012 SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE; reset state IDLE.
REQ-014 SHALL, on a rising edge with go=1 in IDLE or DONE, latch tap_sel, seed and pre_len, and enter LOAD.
REQ-015 SHALL, in LOAD, load the LFSR with the latched seed, clear byte counter k to 0, and enter RUN on the next edge.
REQ-016 SHALL, in RUN, assert mem_wr_en=1 every cycle with mem_waddr = 64 + k, for k = 0..63.
REQ-017 SHALL form plaintext p_k = 0x5F when k < pre_len; otherwise p_k = mem_rdata with mem_raddr = k - pre_len.
REQ-018 SHALL drive mem_wdata = p_k XOR {2'b00, L_k}, where L_0 = seed and L_{k+1} = {L_k[4:0], XOR-reduce(L_k AND taps)}.
REQ-019 SHALL advance the LFSR and increment k once per RUN cycle; after the k=63 write, SHALL enter DONE.
REQ-020 SHALL produce exactly 64 writes per run; go-to-first-write latency SHALL be 2 cycles; go-to-done latency SHALL be 66 cycles.
REQ-021 SHALL hold done=1 in DONE until go (restart, done drops on that edge) or reset.
REQ-022 SHALL ignore go in LOAD and RUN; latched parameters SHALL NOT change mid-run.
REQ-023 SHALL map tap_sel values 6 and 7 to pattern 0 (0x21).
REQ-024 SHALL substitute seed 0x00 with 0x01 to avoid LFSR lockup.
REQ-025 SHALL clamp pre_len values below 7 to 7; 7..15 SHALL be used as given.
REQ-026 SHALL drive mem_wr_en=0, mem_waddr=0, mem_raddr=0 and mem_wdata=0 outside RUN.

Reset
REQ-027 SHALL, on init_n low at any time (including mid-RUN), immediately force state IDLE, k=0, LFSR=0, latched parameters 0, done=0, mem_wr_en=0, with no clock required.
REQ-028 SHALL leave IDLE only on a go following init_n deassertion; partial ciphertext is not cleaned up.

Structure
REQ-029 SHALL take tap pattern constants (6 x 6-bit), preamble character 0x5F, base addresses 0/64, message length 64 and the FSM state enum from shared package lfsr_pkg.
REQ-030 SHALL instantiate one lfsr6b (ports clk, en, init, taps, start, state) as the only sub-module; memory stays external.

Verification
REQ-031 SHALL verify: tap_sel=0, seed=0x01, pre_len=7 -> mem[64..67] = 0x5E, 0x5C, 0x58, 0x50; done rises 66 cycles after go.
REQ-032 SHALL verify: pre_len=10, mem[0]=0x41 -> mem[64..73] hold 0x5F^L_k; mem[74] = 0x41 ^ L_10; mem_raddr=0 at k=10.
REQ-033 SHALL verify: tap_sel=7, seed=0x00 -> output identical to the tap_sel=0, seed=0x01 run; pre_len=3 -> identical to the pre_len=7 run.
REQ-034 SHALL verify: init_n low at k=20 -> mem_wr_en=0 and done=0 in the same cycle; a fresh go then gives full, correct 64-byte output.
REQ-035 SHALL verify: go pulsed during RUN -> no effect, exactly 64 writes; go in DONE -> restart with the new parameters.
REQ-036 SHALL verify: for all 6 taps with random seeds and plaintext, decrypting mem[64..127] with the matching LFSR recovers pre_len x 0x5F followed by mem[0..63-pre_len].
